i2c_rr_arbiter: RTL and testbench
=================================

Name: i2c_rr_arbiter

Overview:
Round-robin arbiter and sequencer that shares one I2C master controller among NUM_REQ requesters (sensor pollers, config loaders). It selects one pending requester and latches that requester's address, R/W, data byte and word count. It then issues a single-cycle start to the controller, waits for the controller's finished indication or a timeout, and returns a per-requester completion pulse. It sits between the client blocks and the I2C controller's i_start/i_addr/i_data_write/i_read_or_write/i_word_cnt/o_finished interface.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
TIMEOUT_CYCLES, 4096, max i_clk cycles spent in WAIT before the transaction is aborted as timed out (>=2)

Ports:
i_clk  input  1  system clock, all logic on rising edge
i_nrst  input  1  reset, synchronous, active-low
i_req  input  NUM_REQ  request level per requester; held until o_done or o_timeout for that requester
i_addr_bus  input  7*NUM_REQ  7-bit slave address per requester, requester k at [7k+6:7k]
i_rw_bus  input  NUM_REQ  read(1)/write(0) per requester
i_data_bus  input  8*NUM_REQ  write byte per requester, requester k at [8k+7:8k]
i_word_cnt_bus  input  3*NUM_REQ  byte count per requester, requester k at [3k+2:3k]
o_grant  output  NUM_REQ  one-hot, high for the owning requester from START through DONE
o_done  output  NUM_REQ  one-cycle pulse to the owner on normal completion
o_timeout  output  NUM_REQ  one-cycle pulse to the owner on timeout
o_busy  output  1  high in every state except IDLE
o_ctl_start  output  1  one-cycle start strobe to the controller
o_ctl_addr  output  7  latched address
o_ctl_rw  output  1  latched R/W
o_ctl_data  output  8  latched write byte
o_ctl_word_cnt  output  3  latched word count
i_ctl_finished  input  1  controller transaction-complete indication

Behaviour:
- Reset (i_nrst low at a rising edge): state=IDLE, rr pointer=0, timer=0, owner index=0. All outputs are 0, including o_ctl_* holding registers. Reset mid-transaction aborts immediately with no o_done/o_timeout pulse. o_ctl_start is 0 from the first reset edge.
- States: IDLE, START, WAIT, DONE (2-bit encoding).
- IDLE:
  - Winner = first set bit of i_req, searching from index ptr upward and wrapping modulo NUM_REQ.
  - If any i_req is set, on the edge: latch owner=winner, latch owner's addr/rw/data/word_cnt into o_ctl_* registers, then go to START.
  - Otherwise stay in IDLE.
- START:
  - o_grant[owner]=1, o_ctl_start=1 (exactly this one cycle), timer cleared to 0.
  - Next state is WAIT unconditionally.
- WAIT:
  - o_ctl_start=0. Timer increments by 1 per cycle. Timer width is clog2(TIMEOUT_CYCLES)+1, and the timer saturates (no wrap).
  - If i_ctl_finished=1: go to DONE with flag to=0.
  - Else if timer==TIMEOUT_CYCLES-1: go to DONE with flag to=1.
  - i_ctl_finished takes priority when both conditions occur on the same cycle.
- DONE:
  - o_done[owner]=1 if to=0, else o_timeout[owner]=1, for one cycle.
  - ptr = (owner+1) mod NUM_REQ. Go to IDLE.
  - o_grant drops at the exit edge.
- Latency:
  - Request seen in IDLE at edge N: START (start strobe) during cycle N..N+1, WAIT from N+1.
  - i_ctl_finished sampled at edge M: DONE pulse in cycle M..M+1, IDLE at M+1.
  - Earliest next START is at edge M+2. Back-to-back turnaround is 2 idle-strobe cycles.
- Latched fields are stable from START until the next grant. Requester inputs may change freely after START without affecting the transaction.
- i_req of the owner dropping during START/WAIT does not abort; the transaction completes and the pulse is still issued.
- i_ctl_finished outside WAIT is ignored, so a stale finished level cannot complete the next transaction early.
- i_word_cnt value 0 is passed through unmodified; the arbiter does not interpret it.
- Fairness: a continuously requesting client waits at most NUM_REQ-1 transactions.

Test Plan:
- Single request: NUM_REQ=4, i_req=4'b0100, addr[2]=7'h50, rw=0, data=8'hA5, wc=3; finished 20 cycles after start -> o_grant=4'b0100, one o_ctl_start pulse, o_ctl_addr=7'h50, o_ctl_data=8'hA5, o_ctl_word_cnt=3, o_done=4'b0100 for 1 cycle, ptr=3.
- Round-robin: i_req=4'b1111 held, each transaction finished after 5 cycles -> grant order 0,1,2,3,0; exactly one o_done per grant; 2-cycle gap between done and next start.
- Wrap priority: ptr=3 (after serving 2), i_req=4'b1001 -> requester 3 granted before 0.
- Timeout: TIMEOUT_CYCLES=16, i_ctl_finished held 0 -> o_timeout[owner] pulses 16 cycles after WAIT entry, o_done stays 0, next requester is served.
- Finished and timeout on the same cycle -> o_done pulses, o_timeout stays 0.
- Robustness: i_ctl_finished=1 in IDLE is ignored. Owner input fields changed during WAIT leave o_ctl_* unchanged. i_nrst low mid-WAIT -> next cycle all outputs 0, no pulse, ptr=0, and a new request is served normally after release.

Source files
------------

// File: rtl/i2c_rr_arbiter.sv
// Round-robin arbiter that shares one I2C master controller among NUM_REQ clients.
// Latches the winner's transaction fields, strobes start, and reports done/timeout.
module i2c_rr_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                   i_clk,
  input  logic                   i_nrst,
  input  logic [NUM_REQ-1:0]     i_req,
  input  logic [7*NUM_REQ-1:0]   i_addr_bus,
  input  logic [NUM_REQ-1:0]     i_rw_bus,
  input  logic [8*NUM_REQ-1:0]   i_data_bus,
  input  logic [3*NUM_REQ-1:0]   i_word_cnt_bus,
  output logic [NUM_REQ-1:0]     o_grant,
  output logic [NUM_REQ-1:0]     o_done,
  output logic [NUM_REQ-1:0]     o_timeout,
  output logic                   o_busy,
  output logic                   o_ctl_start,
  output logic [6:0]             o_ctl_addr,
  output logic                   o_ctl_rw,
  output logic [7:0]             o_ctl_data,
  output logic [2:0]             o_ctl_word_cnt,
  input  logic                   i_ctl_finished
);

  // state | meaning
  // IDLE  | pick next requester from ptr upward, latch its fields
  // START | one-cycle start strobe, timer cleared
  // WAIT  | wait for controller finished or timer terminal count
  // DONE  | one-cycle done/timeout pulse to owner, advance ptr

  localparam int IW = $clog2(NUM_REQ);
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [IW:0]   NR     = (IW+1)'(NUM_REQ);
  localparam logic [IW-1:0] LAST   = IW'(NUM_REQ - 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, WAIT = 2'd2, DONE = 2'd3} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            to_q, to_d;
  logic [6:0]      addr_q, addr_d;
  logic            rw_q, rw_d;
  logic [7:0]      data_q, data_d;
  logic [2:0]      wc_q, wc_d;

  logic [IW-1:0]   win;
  logic            win_vld;
  logic [IW:0]     cand;
  logic [6:0]      addr_sel;
  logic            rw_sel;
  logic [7:0]      data_sel;
  logic [2:0]      wc_sel;
  logic [NUM_REQ-1:0] owner_oh;

  // Descending scan so the smallest offset from ptr is written last and wins.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    cand    = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = {1'b0, ptr_q} + (IW+1)'(i);
      if (cand >= NR) cand = cand - NR;
      if (i_req[cand[IW-1:0]]) begin
        win     = cand[IW-1:0];
        win_vld = 1'b1;
      end
    end
  end

  always_comb begin
    addr_sel = '0;
    rw_sel   = 1'b0;
    data_sel = '0;
    wc_sel   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (win == IW'(k)) begin
        addr_sel = i_addr_bus[7*k +: 7];
        rw_sel   = i_rw_bus[k];
        data_sel = i_data_bus[8*k +: 8];
        wc_sel   = i_word_cnt_bus[3*k +: 3];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    timer_d = timer_q;
    to_d    = to_q;
    addr_d  = addr_q;
    rw_d    = rw_q;
    data_d  = data_q;
    wc_d    = wc_q;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          owner_d = win;
          addr_d  = addr_sel;
          rw_d    = rw_sel;
          data_d  = data_sel;
          wc_d    = wc_sel;
          state_d = START;
        end
      end
      START: begin
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (timer_q != '1) timer_d = timer_q + 1'b1;
        // finished wins over a coincident timeout
        if (i_ctl_finished) begin
          to_d    = 1'b0;
          state_d = DONE;
        end else if (timer_q == T_LAST) begin
          to_d    = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        ptr_d   = (owner_q == LAST) ? '0 : owner_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      timer_q <= '0;
      to_q    <= 1'b0;
      addr_q  <= '0;
      rw_q    <= 1'b0;
      data_q  <= '0;
      wc_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      timer_q <= timer_d;
      to_q    <= to_d;
      addr_q  <= addr_d;
      rw_q    <= rw_d;
      data_q  <= data_d;
      wc_q    <= wc_d;
    end
  end

  assign owner_oh       = {{(NUM_REQ-1){1'b0}}, 1'b1} << owner_q;
  assign o_busy         = (state_q != IDLE);
  assign o_ctl_start    = (state_q == START);
  assign o_grant        = (state_q != IDLE) ? owner_oh : '0;
  assign o_done         = (state_q == DONE && !to_q) ? owner_oh : '0;
  assign o_timeout      = (state_q == DONE && to_q) ? owner_oh : '0;
  assign o_ctl_addr     = addr_q;
  assign o_ctl_rw       = rw_q;
  assign o_ctl_data     = data_q;
  assign o_ctl_word_cnt = wc_q;

endmodule

// File: tb/tb_i2c_rr_arbiter.sv
// Scoreboard bench for i2c_rr_arbiter: driver pushes expected grants/outcomes,
// a negedge monitor pops and compares when the arbiter strobes start or pulses.
module tb_i2c_rr_arbiter;
  localparam int N = 4;
  localparam int T = 16;

  logic             i_clk = 1'b0;
  logic             i_nrst;
  logic [N-1:0]     i_req;
  logic [7*N-1:0]   i_addr_bus;
  logic [N-1:0]     i_rw_bus;
  logic [8*N-1:0]   i_data_bus;
  logic [3*N-1:0]   i_word_cnt_bus;
  logic             i_ctl_finished;
  logic [N-1:0]     o_grant, o_done, o_timeout;
  logic             o_busy, o_ctl_start, o_ctl_rw;
  logic [6:0]       o_ctl_addr;
  logic [7:0]       o_ctl_data;
  logic [2:0]       o_ctl_word_cnt;

  i2c_rr_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(T)) dut (
    .i_clk(i_clk), .i_nrst(i_nrst), .i_req(i_req), .i_addr_bus(i_addr_bus),
    .i_rw_bus(i_rw_bus), .i_data_bus(i_data_bus), .i_word_cnt_bus(i_word_cnt_bus),
    .o_grant(o_grant), .o_done(o_done), .o_timeout(o_timeout), .o_busy(o_busy),
    .o_ctl_start(o_ctl_start), .o_ctl_addr(o_ctl_addr), .o_ctl_rw(o_ctl_rw),
    .o_ctl_data(o_ctl_data), .o_ctl_word_cnt(o_ctl_word_cnt),
    .i_ctl_finished(i_ctl_finished)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    int         idx;
    logic [6:0] a;
    logic       rw;
    logic [7:0] dat;
    logic [2:0] wc;
    bit         to;
    int         lat;
    int         gap;
  } item_t;

  item_t      sb[$];
  item_t      cur;
  bit         active = 1'b0;
  int         cyc = 0;
  int         start_cyc = 0;
  int         last_pulse = -100;
  int         n_checks = 0;
  int         n_fail = 0;
  int         ptr_m = 0;
  bit         at_pulse = 1'b0;
  logic [N-1:0] oh;
  logic [6:0] f_addr [N];
  logic       f_rw   [N];
  logic [7:0] f_dat  [N];
  logic [2:0] f_wc   [N];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic set_fields(input int k, input logic [6:0] a, input logic rw,
                            input logic [7:0] dt, input logic [2:0] wc);
    f_addr[k] = a;
    f_rw[k]   = rw;
    f_dat[k]  = dt;
    f_wc[k]   = wc;
    i_addr_bus[7*k +: 7]     = a;
    i_rw_bus[k]              = rw;
    i_data_bus[8*k +: 8]     = dt;
    i_word_cnt_bus[3*k +: 3] = wc;
  endtask

  task automatic raise(input int k);
    set_fields(k, 7'($urandom), 1'($urandom), 8'($urandom), 3'($urandom));
    i_req[k] = 1'b1;
  endtask

  // Reference rule: first pending requester at or after ptr, wrapping around.
  function automatic int pick(input logic [N-1:0] p, input int ptr);
    for (int i = 0; i < N; i++)
      if (p[(ptr + i) % N]) return (ptr + i) % N;
    return -1;
  endfunction

  // d = WAIT-cycle index at which finished is first presented (d > T means never in time).
  task automatic run_txn(input logic [N-1:0] raise_m, input int d, input bit scramble,
                         input bit stale, input bit abort);
    item_t it;
    int    w;
    int    n;
    bit    got;
    for (int k = 0; k < N; k++)
      if (raise_m[k] && !i_req[k]) raise(k);
    if (i_req == '0) raise(int'($urandom_range(0, N-1)));
    w      = pick(i_req, ptr_m);
    it.idx = w;
    it.a   = f_addr[w];
    it.rw  = f_rw[w];
    it.dat = f_dat[w];
    it.wc  = f_wc[w];
    it.to  = (d > T);
    it.lat = ((d < T) ? d : T) + 1;
    it.gap = at_pulse ? 2 : -1;
    sb.push_back(it);
    ptr_m = (w + 1) % N;

    n = 0;
    while (!o_ctl_start && n < 8) begin
      @(negedge i_clk);
      n++;
    end
    chk("start_seen", 64'(o_ctl_start), 64'(1));
    if (!o_ctl_start) begin
      at_pulse = 1'b0;
      return;
    end

    got = 1'b0;
    for (int j = 1; j <= T + 4; j++) begin
      @(negedge i_clk);
      if ((o_done | o_timeout) != '0) begin
        got = 1'b1;
        break;
      end
      if (abort && j == 3) begin
        i_nrst = 1'b0;
        @(negedge i_clk);
        chk("reset_mid_wait", 64'({o_grant, o_done, o_timeout, o_busy, o_ctl_start,
            o_ctl_addr, o_ctl_rw, o_ctl_data, o_ctl_word_cnt}), 64'(0));
        i_req          = '0;
        i_ctl_finished = 1'b0;
        ptr_m          = 0;
        @(negedge i_clk);
        i_nrst   = 1'b1;
        at_pulse = 1'b0;
        return;
      end
      if (scramble && j == 1)
        set_fields(w, 7'($urandom), 1'($urandom), 8'($urandom), 3'($urandom));
      i_ctl_finished = (j >= d);
    end
    chk("pulse_seen", 64'(got), 64'(1));
    i_req    = i_req & ~(o_done | o_timeout);
    i_req[w] = 1'b0;
    i_ctl_finished = stale;
    at_pulse = got;
  endtask

  always @(negedge i_clk) begin
    cyc++;
    if (!i_nrst) begin
      active = 1'b0;
    end else if (o_ctl_start) begin
      chk("single_start", 64'(active), 64'(0));
      chk("sb_nonempty", 64'(sb.size() != 0), 64'(1));
      if (sb.size() != 0) begin
        cur       = sb.pop_front();
        active    = 1'b1;
        start_cyc = cyc;
        oh        = N'(1) << cur.idx;
        chk("grant_at_start", 64'(o_grant), 64'(oh));
        chk("ctl_fields", 64'({o_ctl_addr, o_ctl_rw, o_ctl_data, o_ctl_word_cnt}),
            64'({cur.a, cur.rw, cur.dat, cur.wc}));
        if (cur.gap >= 0) chk("turnaround", 64'(cyc - last_pulse), 64'(cur.gap));
      end
    end else if (active) begin
      chk("hold", 64'({o_grant, o_busy, o_ctl_addr, o_ctl_rw, o_ctl_data, o_ctl_word_cnt}),
          64'({oh, 1'b1, cur.a, cur.rw, cur.dat, cur.wc}));
      if ((o_done | o_timeout) != '0) begin
        chk("done_pulse", 64'(o_done), 64'(cur.to ? '0 : oh));
        chk("timeout_pulse", 64'(o_timeout), 64'(cur.to ? oh : '0));
        chk("latency", 64'(cyc - start_cyc), 64'(cur.lat));
        active     = 1'b0;
        last_pulse = cyc;
      end
    end else begin
      chk("idle_quiet", 64'({o_done, o_timeout, o_busy, o_grant}), 64'(0));
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got hang, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    i_nrst         = 1'b0;
    i_req          = '0;
    i_addr_bus     = '0;
    i_rw_bus       = '0;
    i_data_bus     = '0;
    i_word_cnt_bus = '0;
    i_ctl_finished = 1'b0;
    for (int k = 0; k < N; k++) set_fields(k, 7'h0, 1'b0, 8'h0, 3'h0);
    repeat (3) @(negedge i_clk);
    chk("reset_outputs", 64'({o_grant, o_done, o_timeout, o_busy, o_ctl_start,
        o_ctl_addr, o_ctl_rw, o_ctl_data, o_ctl_word_cnt}), 64'(0));
    i_nrst = 1'b1;
    @(negedge i_clk);

    set_fields(2, 7'h50, 1'b0, 8'hA5, 3'd3);
    i_req[2] = 1'b1;
    run_txn('0, 10, 1'b1, 1'b0, 1'b0);        // single request, fields scrambled mid-WAIT
    run_txn(4'b1001, 7, 1'b0, 1'b1, 1'b0);    // ptr=3: requester 3 before 0; stale finished after
    run_txn('0, 3, 1'b0, 1'b0, 1'b0);
    run_txn(4'b0010, 40, 1'b0, 1'b0, 1'b0);   // timeout
    run_txn(4'b0100, T, 1'b0, 1'b0, 1'b0);    // finished on the timeout cycle
    run_txn(4'b1000, T + 1, 1'b0, 1'b0, 1'b0);
    run_txn(4'b0001, T - 1, 1'b0, 1'b0, 1'b0);
    run_txn(4'b0000, 1, 1'b0, 1'b0, 1'b0);
    repeat (5) run_txn('1, 5, 1'b0, 1'b0, 1'b0);

    repeat (40)
      run_txn(N'($urandom), int'($urandom_range(1, T + 3)), 1'($urandom), 1'($urandom), 1'b0);

    run_txn(4'b0100, 100, 1'b0, 1'b0, 1'b1);  // reset mid-WAIT
    run_txn(4'b0110, 4, 1'b0, 1'b0, 1'b0);

    guard = 0;
    while (i_req != '0 && guard < 20) begin
      run_txn('0, 2, 1'b0, 1'b0, 1'b0);
      guard++;
    end
    i_ctl_finished = 1'b0;
    repeat (4) @(negedge i_clk);
    chk("sb_drained", 64'(sb.size()), 64'(0));
    chk("no_open_txn", 64'(active), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
